// File: rtl/cpu_defs.sv
// Shared fetch-path definitions: default buffer geometry and the instruction-buffer entry format.
package cpu_defs;

  localparam int unsigned IBUF_FETCH_WIDTH = 2;
  localparam int unsigned IBUF_DEPTH       = 8;
  localparam int unsigned IBUF_EXCP_W      = 6;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            inst;
    logic                   btb_taken;
    logic [31:0]            btb_target;
    logic                   excp_valid;
    logic [IBUF_EXCP_W-1:0] excp_code;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_fifo.sv
// Circular instruction buffer: up to FW compacted entries pushed per cycle, one popped per cycle.
module ibuf_fifo
  import cpu_defs::*;
#(
  parameter int unsigned FW    = IBUF_FETCH_WIDTH,
  parameter int unsigned Depth = IBUF_DEPTH,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned NW   = $clog2(FW + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [NW-1:0]        push_n,
  input  ibuf_entry_t [FW-1:0] push_data,
  input  logic                 pop,
  output ibuf_entry_t          head,
  output logic [CntW-1:0]      count
);

  ibuf_entry_t         mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(push_n);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (push ? CntW'(push_n) : CntW'(0)) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the top masks the head whenever count is zero.
  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(FW); j++) begin
      if (push && !flush && (NW'(j) < push_n)) begin
        mem_q[wr_ptr_q + PtrW'(j)] <= push_data[j];
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch2_ibuf.sv
// Second fetch stage: latches a fetch group, selects slots [start, end] and queues them for decode.
module fetch2_ibuf
  import cpu_defs::*;
#(
  parameter int unsigned FETCH_WIDTH = IBUF_FETCH_WIDTH,
  parameter int unsigned DEPTH       = IBUF_DEPTH,
  parameter int unsigned EXCP_W      = IBUF_EXCP_W,
  localparam int unsigned SlotW      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int unsigned OccW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic                      in_btb_taken,
  input  logic [SlotW-1:0]          in_btb_slot,
  input  logic [31:0]               in_btb_target,
  input  logic                      in_excp_valid,
  input  logic [EXCP_W-1:0]         in_excp_code,
  output logic                      rdy_in,
  input  logic [32*FETCH_WIDTH-1:0] icache_data,
  input  logic                      icache_data_valid,
  input  logic                      next_rdy_in,
  output logic                      out_valid,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic                      out_btb_taken,
  output logic [31:0]               out_btb_target,
  output logic                      out_excp_valid,
  output logic [EXCP_W-1:0]         out_excp_code,
  output logic [OccW-1:0]           occupancy
);

  localparam int unsigned NW = $clog2(FETCH_WIDTH + 1);
  localparam logic [SlotW-1:0] SlotMask = SlotW'(FETCH_WIDTH - 1);

  function automatic int unsigned clamp_slot(input int unsigned k);
    return (k > FETCH_WIDTH - 1) ? FETCH_WIDTH - 1 : k;
  endfunction

  logic              reg_valid_q, reg_valid_d;
  logic [31:0]       reg_pc_q, reg_pc_d;
  logic              reg_taken_q, reg_taken_d;
  logic [SlotW-1:0]  reg_slot_q, reg_slot_d;
  logic [31:0]       reg_target_q, reg_target_d;
  logic              reg_excp_q, reg_excp_d;
  logic [EXCP_W-1:0] reg_code_q, reg_code_d;

  logic [SlotW-1:0]             start_slot, end_slot, slot_m;
  logic                         taken_eff;
  logic [31:0]                  base_pc;
  logic [NW-1:0]                push_n;
  ibuf_entry_t [FETCH_WIDTH-1:0] push_data;
  logic                         space_ok, push_ok, pop, has_data;
  ibuf_entry_t                  head;
  logic [OccW-1:0]              count;

  // Flush wins over a load so a group presented during redirect is discarded.
  always_comb begin
    reg_valid_d  = reg_valid_q;
    reg_pc_d     = reg_pc_q;
    reg_taken_d  = reg_taken_q;
    reg_slot_d   = reg_slot_q;
    reg_target_d = reg_target_q;
    reg_excp_d   = reg_excp_q;
    reg_code_d   = reg_code_q;
    if (flush) begin
      reg_valid_d = 1'b0;
    end else if (rdy_in) begin
      reg_valid_d  = in_valid;
      reg_pc_d     = in_pc;
      reg_taken_d  = in_btb_taken;
      reg_slot_d   = in_btb_slot;
      reg_target_d = in_btb_target;
      reg_excp_d   = in_excp_valid;
      reg_code_d   = in_excp_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_valid_q  <= 1'b0;
      reg_pc_q     <= '0;
      reg_taken_q  <= 1'b0;
      reg_slot_q   <= '0;
      reg_target_q <= '0;
      reg_excp_q   <= 1'b0;
      reg_code_q   <= '0;
    end else begin
      reg_valid_q  <= reg_valid_d;
      reg_pc_q     <= reg_pc_d;
      reg_taken_q  <= reg_taken_d;
      reg_slot_q   <= reg_slot_d;
      reg_target_q <= reg_target_d;
      reg_excp_q   <= reg_excp_d;
      reg_code_q   <= reg_code_d;
    end
  end

  always_comb begin
    start_slot = reg_pc_q[2 +: SlotW] & SlotMask;
    slot_m     = reg_slot_q & SlotMask;
    // A predicted slot before the group start cannot be reached; ignore the prediction.
    taken_eff  = reg_taken_q && (slot_m >= start_slot);
    end_slot   = taken_eff ? slot_m : SlotMask;
    base_pc    = reg_pc_q & ~(32'(FETCH_WIDTH * 4) - 32'd1);
    push_n     = reg_excp_q ? NW'(1) : (NW'(end_slot) - NW'(start_slot) + NW'(1));
    for (int j = 0; j < int'(FETCH_WIDTH); j++) begin
      push_data[j].pc         = base_pc | (32'(clamp_slot(32'(start_slot) + 32'(j))) << 2);
      push_data[j].inst       = icache_data[clamp_slot(32'(start_slot) + 32'(j)) * 32 +: 32];
      push_data[j].btb_taken  = taken_eff &&
                                (clamp_slot(32'(start_slot) + 32'(j)) == 32'(end_slot));
      push_data[j].btb_target = push_data[j].btb_taken ? reg_target_q : 32'd0;
      push_data[j].excp_valid = 1'b0;
      push_data[j].excp_code  = '0;
    end
    if (reg_excp_q) begin
      push_data[0].pc         = base_pc | (32'(start_slot) << 2);
      push_data[0].inst       = '0;
      push_data[0].btb_taken  = 1'b0;
      push_data[0].btb_target = '0;
      push_data[0].excp_valid = 1'b1;
      push_data[0].excp_code  = IBUF_EXCP_W'(reg_code_q);
    end
  end

  // Free space is judged on the current count; a same-cycle pop earns no credit.
  assign space_ok = (DEPTH - 32'(count)) >= FETCH_WIDTH;
  assign push_ok  = reg_valid_q & ~flush & (reg_excp_q | icache_data_valid) & space_ok;
  assign rdy_in   = flush | ~reg_valid_q | push_ok;

  assign has_data  = (count != '0);
  assign out_valid = has_data & ~flush;
  assign pop       = out_valid & next_rdy_in;

  ibuf_fifo #(
    .FW    (FETCH_WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push_ok),
    .push_n    (push_n),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_pc         = has_data ? head.pc : 32'd0;
  assign out_inst       = has_data ? head.inst : 32'd0;
  assign out_btb_taken  = has_data & head.btb_taken;
  assign out_btb_target = has_data ? head.btb_target : 32'd0;
  assign out_excp_valid = has_data & head.excp_valid;
  assign out_excp_code  = has_data ? EXCP_W'(head.excp_code) : '0;
  assign occupancy      = count;

endmodule

// File: tb/tb_fetch2_ibuf.sv
// Directed bench for fetch2_ibuf with FW=2, DEPTH=8 and hand-computed expectations.
module tb_fetch2_ibuf;

  localparam int unsigned FW     = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned EXCP_W = 6;

  logic              clk, rst_n, flush;
  logic              in_valid, in_btb_taken, in_excp_valid;
  logic [31:0]       in_pc, in_btb_target;
  logic [0:0]        in_btb_slot;
  logic [EXCP_W-1:0] in_excp_code;
  logic              rdy_in;
  logic [63:0]       icache_data;
  logic              icache_data_valid, next_rdy_in;
  logic              out_valid, out_btb_taken, out_excp_valid;
  logic [31:0]       out_pc, out_inst, out_btb_target;
  logic [EXCP_W-1:0] out_excp_code;
  logic [3:0]        occupancy;

  int n_checks;
  int n_pass;

  fetch2_ibuf #(
    .FETCH_WIDTH (FW),
    .DEPTH       (DEPTH),
    .EXCP_W      (EXCP_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_pc             (in_pc),
    .in_btb_taken      (in_btb_taken),
    .in_btb_slot       (in_btb_slot),
    .in_btb_target     (in_btb_target),
    .in_excp_valid     (in_excp_valid),
    .in_excp_code      (in_excp_code),
    .rdy_in            (rdy_in),
    .icache_data       (icache_data),
    .icache_data_valid (icache_data_valid),
    .next_rdy_in       (next_rdy_in),
    .out_valid         (out_valid),
    .out_pc            (out_pc),
    .out_inst          (out_inst),
    .out_btb_taken     (out_btb_taken),
    .out_btb_target    (out_btb_target),
    .out_excp_valid    (out_excp_valid),
    .out_excp_code     (out_excp_code),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a group for one edge, then supply its i-cache data for the following edge.
  task automatic send_group(input logic [31:0] pc, input logic [63:0] data);
    in_valid = 1'b1;
    in_pc    = pc;
    tick();
    in_valid    = 1'b0;
    icache_data = data;
    tick();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_btb_taken = 1'b0; in_btb_slot = '0;
    in_btb_target = '0; in_excp_valid = 1'b0; in_excp_code = '0;
    icache_data = '0; icache_data_valid = 1'b0; next_rdy_in = 1'b0;
    n_checks = 0; n_pass = 0;

    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_rdy_in", 64'(rdy_in), 64'd1);
    check("reset_out_pc", 64'(out_pc), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_rdy_in = 1'b1;
    icache_data_valid = 1'b1;

    // Aligned group: both slots, in order.
    send_group(32'h1C00_0000, {32'h0000_00D1, 32'h0000_00D0});
    check("aligned_pc0", 64'(out_pc), 64'h1C00_0000);
    check("aligned_inst0", 64'(out_inst), 64'hD0);
    check("aligned_occ2", 64'(occupancy), 64'd2);
    tick();
    check("aligned_pc1", 64'(out_pc), 64'h1C00_0004);
    check("aligned_inst1", 64'(out_inst), 64'hD1);
    tick();
    check("aligned_empty", 64'(out_valid), 64'd0);

    // Misaligned group: slot 1 only.
    send_group(32'h1C00_0004, {32'h0000_00D3, 32'h0000_00D2});
    check("misal_pc", 64'(out_pc), 64'h1C00_0004);
    check("misal_inst", 64'(out_inst), 64'hD3);
    check("misal_occ1", 64'(occupancy), 64'd1);
    tick();
    check("misal_empty", 64'(occupancy), 64'd0);

    // Predicted taken at slot 0: slot 1 dropped.
    in_btb_taken = 1'b1; in_btb_slot = 1'b0; in_btb_target = 32'h1C00_0100;
    send_group(32'h1C00_0000, {32'h0000_00D5, 32'h0000_00D4});
    in_btb_taken = 1'b0; in_btb_target = '0;
    check("btb_inst", 64'(out_inst), 64'hD4);
    check("btb_taken", 64'(out_btb_taken), 64'd1);
    check("btb_target", 64'(out_btb_target), 64'h1C00_0100);
    check("btb_occ1", 64'(occupancy), 64'd1);
    tick();
    check("btb_dropped", 64'(occupancy), 64'd0);

    // Exception group with no i-cache data.
    icache_data_valid = 1'b0;
    in_excp_valid = 1'b1; in_excp_code = 6'h08;
    send_group(32'h1C00_0010, {32'h0000_00D7, 32'h0000_00D6});
    in_excp_valid = 1'b0; in_excp_code = '0;
    check("excp_valid", 64'(out_excp_valid), 64'd1);
    check("excp_code", 64'(out_excp_code), 64'h08);
    check("excp_inst", 64'(out_inst), 64'd0);
    check("excp_pc", 64'(out_pc), 64'h1C00_0010);
    check("excp_occ1", 64'(occupancy), 64'd1);
    tick();
    icache_data_valid = 1'b1;
    check("excp_empty", 64'(occupancy), 64'd0);

    // Fill to DEPTH with decode stalled; pointers start at 5 so the run wraps.
    next_rdy_in = 1'b0;
    for (int g = 0; g < 4; g++) begin
      send_group(32'h1C00_1000 + 32'(8 * g),
                 {32'hB000_0000 + 32'(2 * g + 1), 32'hB000_0000 + 32'(2 * g)});
    end
    check("full_occ8", 64'(occupancy), 64'd8);
    in_valid = 1'b1; in_pc = 32'h1C00_1020;
    tick();
    in_valid = 1'b0;
    icache_data = {32'hB000_0009, 32'hB000_0008};
    #1;
    check("full_rdy_in_low", 64'(rdy_in), 64'd0);
    tick();
    check("full_hold_occ8", 64'(occupancy), 64'd8);
    check("full_head_pc", 64'(out_pc), 64'h1C00_1000);
    next_rdy_in = 1'b1;
    #1;
    for (int m = 0; m < 10; m++) begin
      check($sformatf("drain_pc%0d", m), 64'(out_pc), 64'h1C00_1000 + 64'(4 * m));
      check($sformatf("drain_inst%0d", m), 64'(out_inst), 64'hB000_0000 + 64'(m));
      tick();
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_occ0", 64'(occupancy), 64'd0);

    // Build occupancy 5, then flush while a push and pop would both fire.
    next_rdy_in = 1'b0;
    send_group(32'h1C00_2000, {32'h0000_00E1, 32'h0000_00E0});
    send_group(32'h1C00_2008, {32'h0000_00E3, 32'h0000_00E2});
    send_group(32'h1C00_2014, {32'h0000_00E5, 32'h0000_00E4});
    check("pre_flush_occ5", 64'(occupancy), 64'd5);
    in_valid = 1'b1; in_pc = 32'h1C00_3000;
    tick();
    icache_data = {32'h0000_00F1, 32'h0000_00F0};
    next_rdy_in = 1'b1;
    in_pc = 32'h1C00_4000;
    flush = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_rdy_in", 64'(rdy_in), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("post_flush_occ0", 64'(occupancy), 64'd0);
    check("post_flush_valid", 64'(out_valid), 64'd0);
    repeat (3) tick();
    check("post_flush_still_empty", 64'(occupancy), 64'd0);
    check("post_flush_no_entry", 64'(out_valid), 64'd0);

    // Normal operation resumes from pointer zero.
    send_group(32'h1C00_0000, {32'h0000_00F3, 32'h0000_00F2});
    check("resume_pc", 64'(out_pc), 64'h1C00_0000);
    check("resume_inst", 64'(out_inst), 64'hF2);
    check("resume_occ2", 64'(occupancy), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch2_ibuf.md
Name: fetch2_ibuf

Overview:
- Parametrised second fetch stage. Latches one fetch-group request from fetch1, takes the FETCH_WIDTH-word i-cache line segment, and splits it into per-instruction entries.
- Entries go into a DEPTH-entry instruction FIFO that decouples i-cache latency from decode back-pressure. Decode receives one instruction per cycle.
- Supports fetch-group alignment, truncation at a BTB-predicted-taken slot, exception bypass and single-cycle flush.

Parameters:
- FETCH_WIDTH, 2, instructions per fetch group; power of 2, 1..8.
- DEPTH, 8, FIFO entries; power of 2, must be >= FETCH_WIDTH.
- EXCP_W, 6, exception code width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (redirect)
- in_valid  in  1  fetch1 group valid
- in_pc  in  32  group pc (word aligned)
- in_btb_taken  in  1  BTB predicts taken within group
- in_btb_slot  in  $clog2(FETCH_WIDTH) (min 1)  slot index of predicted branch
- in_btb_target  in  32  predicted target
- in_excp_valid  in  1  fetch1 exception (ADEF/TLB)
- in_excp_code  in  EXCP_W  exception code
- rdy_in  out  1  stage register may load this cycle
- icache_data  in  32*FETCH_WIDTH  slot k at bits [32k+31:32k]
- icache_data_valid  in  1  icache_data valid for latched request
- next_rdy_in  in  1  decode accepts
- out_valid  out  1  head entry valid
- out_pc  out  32  head pc
- out_inst  out  32  head instruction
- out_btb_taken  out  1  head predicted taken
- out_btb_target  out  32  head predicted target
- out_excp_valid  out  1  head carries exception
- out_excp_code  out  EXCP_W  head exception code
- occupancy  out  $clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset: stage reg valid=0, rd/wr ptr=0, count=0. All out_* = 0, occupancy = 0, rdy_in = 1.
- L = log2(FETCH_WIDTH). Start slot s = in_pc[2+L-1:2] (s = 0 when FW = 1). Slot k pc = {pc[31:2+L], k[L-1:0], 2'b00}.
- End slot e = in_btb_taken ? in_btb_slot : FW-1. If e < s, treat as e = FW-1 and btb_taken = 0.
- Number of pushed entries n = e - s + 1. Slots outside [s, e] are dropped.
- Only slot e carries btb_taken/btb_target. All other entries carry taken = 0, target = 0.
- Stage register loads {in_*} on the rising edge when rdy_in = 1.
- push_ok = reg.valid & ~flush & (reg.excp_valid | icache_data_valid) & (DEPTH - count >= FW).
  - Free space uses the current count only; a same-cycle pop is not credited.
- rdy_in = flush | ~reg.valid | push_ok (combinational).
- Exception group: push exactly one entry at slot s with inst = 0, excp_valid = 1, code, taken = 0. icache_data_valid is ignored.
- Normal group: push n entries in slot order s..e, in consecutive FIFO locations. wr_ptr += n, modulo DEPTH.
- out_valid = (count != 0) & ~flush. out_* = entry at rd_ptr; out_* = 0 when count = 0.
- pop = out_valid & next_rdy_in; rd_ptr += 1, modulo DEPTH.
- count_next = count + (push_ok ? n : 0) - (pop ? 1 : 0). Simultaneous push and pop are legal, including at count = DEPTH - FW.
- Full: when DEPTH - count < FW, no push. The stage register holds, rdy_in = 0 (if reg.valid), and icache data stays pending. The i-cache holds data valid until rdy_in is seen.
- Empty: out_valid = 0 and pop is impossible.
- Pointer wrap: both pointers are L_D = log2(DEPTH) bits and wrap naturally. Entries can straddle the wrap point.
- Flush: next edge sets reg.valid = 0, count = 0 and rd_ptr = wr_ptr = 0. Any same-cycle push and pop are suppressed. Any fetch1 group presented in the flush cycle is not latched (reg.valid cleared takes priority over the load).
- Reset mid-operation: async clear as above, regardless of clk.

Decomposition:
- cpu_defs package: ibuf_entry_t {pc, inst, btb_taken, btb_target, excp_valid, excp_code}, FETCH_WIDTH and IBUF_DEPTH defaults, EXCP_W.
- Sub-module ibuf_fifo: multi-push (1..FW per cycle), single-pop circular buffer with count. fetch2_ibuf holds the stage register and slot-selection/compaction logic.

Test Plan:
- FW=2, DEPTH=8; group pc=0x1C000000, data valid same cycle, decode always ready -> two entries out on consecutive cycles: pc 0x1C000000 then 0x1C000004, insts = slot0 then slot1.
- Misaligned group pc=0x1C000004 -> single entry, pc 0x1C000004, inst = slot1. The slot-0 word is never output.
- pc=0x1C000000, btb_taken=1, slot=0, target=0x1C000100 -> one entry with taken=1 and target 0x1C000100; slot1 is dropped.
- next_rdy_in=0 while pushing 4 full groups -> occupancy = 8 and rdy_in = 0 on the 5th group. Release ready -> 8 pops in order, correct across the wrap, then the 5th group pushes.
- in_excp_valid=1, code=0x08, icache_data_valid=0 -> one entry with excp_valid=1, code=0x08, inst=0.
- occupancy=5 with push and pop in the same cycle, flush asserted -> next cycle occupancy=0, out_valid=0, and no entry from that cycle ever appears.
